// File: rtl/motoro3_pkg.sv
// Shared types and default timing for the motoro3 drive control blocks.
package motoro3_pkg;

    localparam int FREQ_W = 10;

    localparam logic [FREQ_W-1:0] FREQ_MIN_DEF = 10'd1000;
    localparam int STEP_DIV_DEF = 10000;
    localparam int DEAD_CYC_DEF = 100000;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        RUN,
        STOPPING,
        DEAD
    } m3ctl_state_t;

endpackage

// File: rtl/motoro3_tick.sv
// Ramp prescaler: a down-counter that emits a one-cycle tick every STEP_DIV
// enabled cycles, restarting a full period whenever clr is asserted.
module motoro3_tick #(
    parameter int STEP_DIV = motoro3_pkg::STEP_DIV_DEF
) (
    input  logic clk,
    input  logic nRst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
        end
    end

    assign tick = en & (cnt == '0);

endmodule

// File: rtl/motoro3_ramp_ctrl.sv
// Command sequencer for motoro3_top: rate-limited speed ramps, ramp-down and
// dead time before any stop or reversal, and an immediate fault stop.
//
// state    | meaning
// IDLE     | drive off at minimum speed, waiting for a pending run
// RAMP     | drive on, stepping m3freq toward the pending target
// RUN      | drive on at target speed
// STOPPING | drive on, ramping down to minimum before switching off
// DEAD     | drive off, dead-time counter running (held while fault is high)
module motoro3_ramp_ctrl
    import motoro3_pkg::*;
#(
    parameter logic [FREQ_W-1:0] FREQ_MIN = FREQ_MIN_DEF,
    parameter int STEP     = 1,
    parameter int STEP_DIV = STEP_DIV_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_run,
    input  logic              cmd_rev,
    input  logic [FREQ_W-1:0] cmd_freq,
    input  logic              fault,
    output logic              m3start,
    output logic              m3invOrStop,
    output logic [FREQ_W-1:0] m3freq,
    output logic              at_speed,
    output logic              busy
);

    localparam int DW = $clog2(DEAD_CYC);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [FREQ_W:0] STEP_X = (FREQ_W + 1)'(STEP);
    localparam logic [FREQ_W-1:0] STEP_N = FREQ_W'(STEP);
    localparam logic [FREQ_W:0] FMIN_X = {1'b0, FREQ_MIN};

    m3ctl_state_t state, nxt_state;

    logic              pend_run, pend_rev;
    logic [FREQ_W-1:0] pend_tgt;
    logic              dir, nxt_dir, nxt_start;
    logic [FREQ_W-1:0] nxt_freq, ramp_freq, stop_freq, dn_diff;
    logic [FREQ_W:0]   freq_x, tgt_x, up_sum;
    logic [DW-1:0]     dead_cnt, nxt_dead;
    logic              accept, need_stop, tick, tick_clr, tick_en;

    assign cmd_ready   = ~fault;
    assign accept      = cmd_valid & cmd_ready;
    assign need_stop   = ~pend_run | (pend_rev != dir);
    assign m3invOrStop = dir;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pend_run <= 1'b0;
            pend_rev <= 1'b0;
            pend_tgt <= FREQ_MIN;
        end else if (fault) begin
            pend_run <= 1'b0;
        end else if (accept) begin
            pend_run <= cmd_run;
            pend_rev <= cmd_rev;
            pend_tgt <= (cmd_freq < FREQ_MIN) ? FREQ_MIN : cmd_freq;
        end
    end

    // 11-bit ramp arithmetic so neither direction can wrap.
    assign freq_x  = {1'b0, m3freq};
    assign tgt_x   = {1'b0, pend_tgt};
    assign up_sum  = freq_x + STEP_X;
    assign dn_diff = m3freq - STEP_N;

    always_comb begin
        ramp_freq = pend_tgt;
        if (freq_x < tgt_x) begin
            if (up_sum <= tgt_x) ramp_freq = up_sum[FREQ_W-1:0];
        end else if (freq_x >= tgt_x + STEP_X) begin
            ramp_freq = dn_diff;
        end
        stop_freq = (freq_x >= FMIN_X + STEP_X) ? dn_diff : FREQ_MIN;
    end

    always_comb begin
        nxt_state = state;
        nxt_start = m3start;
        nxt_dir   = dir;
        nxt_freq  = m3freq;
        nxt_dead  = dead_cnt;
        case (state)
            IDLE: begin
                nxt_start = 1'b0;
                nxt_freq  = FREQ_MIN;
                if (pend_run) begin
                    nxt_dir   = pend_rev;
                    nxt_start = 1'b1;
                    nxt_state = (pend_tgt == FREQ_MIN) ? RUN : RAMP;
                end
            end
            RAMP: begin
                if (need_stop) begin
                    nxt_state = STOPPING;
                end else if (m3freq == pend_tgt) begin
                    nxt_state = RUN;
                end else if (tick) begin
                    nxt_freq = ramp_freq;
                end
            end
            RUN: begin
                if (need_stop) begin
                    nxt_state = STOPPING;
                end else if (pend_tgt != m3freq) begin
                    nxt_state = RAMP;
                end
            end
            STOPPING: begin
                if (!need_stop) begin
                    nxt_state = RAMP;
                end else if (m3freq == FREQ_MIN) begin
                    nxt_start = 1'b0;
                    nxt_state = DEAD;
                    // The IDLE cycle before a restart is also drive-off time,
                    // so it is counted up front to keep the window DEAD_CYC long.
                    nxt_dead  = DW'(1);
                end else if (tick) begin
                    nxt_freq = stop_freq;
                end
            end
            DEAD: begin
                nxt_start = 1'b0;
                if (dead_cnt == DEAD_LAST) begin
                    nxt_state = IDLE;
                    nxt_dead  = '0;
                end else begin
                    nxt_dead = dead_cnt + DW'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_start = 1'b0;
                nxt_freq  = FREQ_MIN;
                nxt_dead  = '0;
            end
        endcase
        if (fault) begin
            nxt_state = DEAD;
            nxt_start = 1'b0;
            nxt_freq  = FREQ_MIN;
            nxt_dead  = '0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            m3start  <= 1'b0;
            dir      <= 1'b0;
            m3freq   <= FREQ_MIN;
            dead_cnt <= '0;
            at_speed <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt_state;
            m3start  <= nxt_start;
            dir      <= nxt_dir;
            m3freq   <= nxt_freq;
            dead_cnt <= nxt_dead;
            at_speed <= (nxt_state == RUN) & nxt_start;
            busy     <= (nxt_state != IDLE);
        end
    end

    assign tick_en  = (state == RAMP) | (state == STOPPING);
    assign tick_clr = (nxt_state != state) & ((nxt_state == RAMP) | (nxt_state == STOPPING));

    motoro3_tick #(
        .STEP_DIV(STEP_DIV)
    ) u_tick (
        .clk (clk),
        .nRst(nRst),
        .clr (tick_clr),
        .en  (tick_en),
        .tick(tick)
    );

endmodule

// File: doc/motoro3_ramp_ctrl.md
# motoro3_ramp_ctrl

Command sequencer for the three-phase motor drive. It takes run, stop, direction and speed commands over a valid/ready handshake and drives the `m3start`, `m3invOrStop` and `m3freq` inputs of `motoro3_top`. Speed changes follow a rate-limited ramp. A stop or a direction reversal always ramps down to minimum speed first, then de-energises the drive, then waits a dead time. A fault input forces an immediate stop. The block sits between the host or command logic and `motoro3_top`, in the same 10 MHz `clk` domain.

## Interface
Parameters:
- `FREQ_MIN`, 10'd1000: minimum and start speed code; the drive's lower clamp.
- `STEP`, 1: speed-code change per ramp tick.
- `STEP_DIV`, 10000: `clk` cycles per ramp tick (1 ms at 10 MHz); must be ≥ 2.
- `DEAD_CYC`, 100000: `clk` cycles with the drive off between stop and restart (10 ms).

Ports:
- `clk`, input, 1: 10 MHz clock; the only clock.
- `nRst`, input, 1: reset, asynchronous, active-low.
- `cmd_valid`, input, 1: command offered.
- `cmd_ready`, output, 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_run`, input, 1: 1 = run, 0 = stop.
- `cmd_rev`, input, 1: requested direction; 1 = reverse.
- `cmd_freq`, input, 10: target speed code.
- `fault`, input, 1: synchronous level; 1 = emergency stop.
- `m3start`, output, 1: drive enable to `motoro3_top`.
- `m3invOrStop`, output, 1: direction to `motoro3_top`.
- `m3freq`, output, 10: speed code to `motoro3_top`.
- `at_speed`, output, 1: running with `m3freq == target`.
- `busy`, output, 1: state is not IDLE.

## Operation
- **Accepting commands.** An accepted command loads the pending registers `pend_run`, `pend_rev` and `pend_tgt`.
  - `pend_tgt = max(cmd_freq, FREQ_MIN)`.
  - A later accepted command overwrites the earlier one; there is no queue.
- **Handshake.** `cmd_ready = ~fault`, combinational; it is held low for every cycle `fault` is high.
- **Derived signals.** `dir` is the registered direction currently driven on `m3invOrStop`. `need_stop = ~pend_run | (pend_rev != dir)`.
- **States.** IDLE, RAMP, RUN, STOPPING, DEAD.
- **IDLE.** `m3start=0`, `m3freq=FREQ_MIN`. When `pend_run` is 1:
  - `dir <= pend_rev` and `m3start <= 1`.
  - Go to RUN if `pend_tgt == FREQ_MIN`, otherwise go to RAMP.
- **RAMP.** On each tick, move `m3freq` toward `pend_tgt` by `STEP` in either direction, saturating at `pend_tgt`.
  - Go to RUN when `m3freq == pend_tgt`.
  - Go to STOPPING if `need_stop`.
- **RUN.**
  - Go to STOPPING if `need_stop`.
  - Otherwise go to RAMP if `pend_tgt != m3freq`.
- **STOPPING.** On each tick, `m3freq` decreases by `STEP`, saturating at `FREQ_MIN`.
  - When `m3freq == FREQ_MIN`, set `m3start <= 0` and go to DEAD.
  - If `need_stop` clears before that, return to RAMP with no `m3start` drop.
- **DEAD.** `m3start=0`. The counter runs for `DEAD_CYC` cycles, then the block goes to IDLE, which restarts immediately if `pend_run` is 1.
- **Direction changes.** `m3invOrStop` changes only in the IDLE-to-start transition, so it never toggles while `m3start` is 1.
- **Fault.** `fault` has priority over everything else. The next cycle gives:
  - `m3start=0`, `m3freq=FREQ_MIN`, `pend_run=0`, state DEAD with the dead counter cleared.
  - The dead counter is held at 0 while `fault` is high and counts after it falls.
  - The block ends in IDLE and does not restart until a new run command arrives.
- **Status outputs.**
  - `at_speed` = (state == RUN) & `m3start`.
  - `busy` = (state != IDLE).

## Timing
- **Reset values.**
  - Outputs: `m3start=0`, `m3invOrStop=0`, `m3freq=FREQ_MIN`, `at_speed=0`, `busy=0`, `cmd_ready=1` (when `fault` is 0).
  - Internal: state IDLE, `pend_run=0`, `pend_rev=0`, `pend_tgt=FREQ_MIN`, all counters 0.
- **Registered outputs.** `m3start`, `m3invOrStop`, `m3freq`, `at_speed` and `busy` are registered.
- **Start latency.** A run command accepted in cycle N while IDLE gives `m3start=1` in N+2: N+1 is pending-register load, N+2 is the FSM start.
- **Ramp tick.** The prescaler clears on entering RAMP or STOPPING. Ticks occur every `STEP_DIV` cycles; the first step comes `STEP_DIV` cycles after entry.
  - A change of target within RAMP does not clear the prescaler.
- **Ramp arithmetic.** Computed at 11 bits with saturation, so there is no wrap past 1023 or below `FREQ_MIN`.
- **Dead time.** Exactly `DEAD_CYC` cycles with `m3start=0`, counted after `fault` is low.
- **Reset mid-operation.** Asserting `nRst` at any point clears the block to the reset values immediately, asynchronously.

## Structure
- **Shared package `motoro3_pkg`:**
  - `FREQ_W = 10`.
  - The state enum `m3ctl_state_t` (IDLE, RAMP, RUN, STOPPING, DEAD).
  - Defaults for `FREQ_MIN`, `STEP_DIV` and `DEAD_CYC`.
- **Sub-module `motoro3_tick`:** a prescaler with clear and enable inputs, producing a one-cycle `tick` every `STEP_DIV` cycles. It is reused for ramp ticks.
- The dead counter stays inline in this block.

## Test plan
Use `STEP_DIV=4`, `DEAD_CYC=8`, `FREQ_MIN=1000`, `STEP=1` for all scenarios.
1. **Reset and start.** Check all reset values. Send run, rev=0, freq=1010 → `m3start` rises 2 cycles after accept, `m3freq` rises 1 every 4 cycles, reaches 1010 after 40 cycles, then `at_speed=1`.
2. **Low target clamp.** Send run with freq=900 → `pend_tgt=1000`, RUN reached directly, `at_speed=1`, `m3freq` stays 1000.
3. **Reversal.** At 1010 forward, send rev=1 → ramp down to 1000 in 40 cycles, `m3start=0` for exactly 8 cycles, `m3invOrStop=1`, `m3start=1`, ramp up to 1010.
4. **Cancelled stop.** During STOPPING at 1005, send run, rev=0, freq=1015 → back to RAMP, `m3start` never drops, `m3freq` reaches 1015.
5. **Fault during ramp.** Assert `fault` 3 cycles into RAMP at 1002 → next cycle `m3start=0`, `m3freq=1000`, `cmd_ready=0`. Release `fault` → IDLE after 8 cycles with no restart.
6. **Async reset mid-ramp.** Pulse `nRst` low mid-cycle during RAMP → outputs reach reset values immediately, with no clock edge needed.
